// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load response wait, data align/extend, flush discard tracking.
// Optional MEM-to-decode bypass enabled by defining MS_BYPASS_EN.
module mem_stage #(
  parameter int SIDE_WD         = 150,
  parameter int ES_TO_MS_BUS_WD = 76 + SIDE_WD,
  parameter int MS_TO_WS_BUS_WD = 70 + SIDE_WD + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_flush_pipe,
  output logic                       ms_ex,
  output logic [38:0]                ms_fwd_bus
);

  localparam int ES_REQ_BIT = 74;
  // vaddr occupies the low 32 sideband bits with ertn directly above it
  localparam int ERTN_BIT   = 32;

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
  logic [1:0]                 discard_cnt_q, discard_cnt_d;
  logic                       rdata_buf_valid_q, rdata_buf_valid_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;

  logic [SIDE_WD-1:0] ms_side;
  logic               ms_ex_flag, ms_req_issued, ms_mem_re, ms_gr_we;
  logic [2:0]         ms_mem_type;
  logic [4:0]         ms_dest;
  logic [31:0]        ms_alu_result, ms_pc;

  assign {ms_side, ms_ex_flag, ms_req_issued, ms_mem_type, ms_mem_re, ms_gr_we,
          ms_dest, ms_alu_result, ms_pc} = es_bus_q;

  logic need_resp, data_ok_accepted, ms_ready_go, ms_leave;
  logic inc_ms, inc_es, dec_cnt;

  assign need_resp        = ms_valid_q && ms_req_issued;
  assign data_ok_accepted = data_sram_data_ok && (discard_cnt_q == 2'd0);
  assign ms_ready_go      = !need_resp || rdata_buf_valid_q || data_ok_accepted;
  assign ms_allowin       = (!ms_valid_q || (ms_ready_go && ws_allowin)) && (discard_cnt_q == 2'd0);
  assign ms_to_ws_valid   = ms_valid_q && ms_ready_go;
  assign ms_leave         = ms_to_ws_valid && ws_allowin;

  // Requests killed by a flush still owe a data_ok; count them so it is dropped
  assign inc_ms  = ws_flush_pipe && need_resp && !rdata_buf_valid_q && !data_sram_data_ok;
  assign inc_es  = ws_flush_pipe && es_to_ms_valid && es_to_ms_bus[ES_REQ_BIT];
  assign dec_cnt = data_sram_data_ok && (discard_cnt_q != 2'd0);

  always_comb begin
    ms_valid_d        = ms_valid_q;
    rdata_buf_valid_d = rdata_buf_valid_q;
    rdata_buf_d       = rdata_buf_q;
    discard_cnt_d     = discard_cnt_q + {1'b0, inc_ms} + {1'b0, inc_es} - {1'b0, dec_cnt};

    if (ws_flush_pipe) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    if (ws_flush_pipe || ms_leave) begin
      rdata_buf_valid_d = 1'b0;
    end else if (need_resp && data_ok_accepted && !ws_allowin) begin
      rdata_buf_valid_d = 1'b1;
      rdata_buf_d       = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid_q        <= 1'b0;
      discard_cnt_q     <= 2'd0;
      rdata_buf_valid_q <= 1'b0;
      rdata_buf_q       <= 32'd0;
    end else begin
      ms_valid_q        <= ms_valid_d;
      discard_cnt_q     <= discard_cnt_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
      rdata_buf_q       <= rdata_buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      es_bus_q <= es_to_ms_bus;
    end
  end

  logic [31:0] load_word, load_ext, final_result;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_word = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;
  assign load_half = ms_alu_result[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_byte = load_word[7:0];
    case (ms_alu_result[1:0])
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      2'd3:    load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
  end

  always_comb begin
    load_ext = load_word;
    case (ms_mem_type)
      3'b001:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b101:  load_ext = {24'd0, load_byte};
      3'b010:  load_ext = {{16{load_half[15]}}, load_half};
      3'b110:  load_ext = {16'd0, load_half};
      default: load_ext = load_word;
    endcase
  end

  assign final_result = ms_mem_re ? load_ext : ms_alu_result;
  assign ms_to_ws_bus = {ms_side, ms_ex_flag, ms_gr_we, ms_dest, final_result, ms_pc};
  assign ms_ex        = ms_valid_q && (ms_ex_flag || ms_side[ERTN_BIT]);

`ifdef MS_BYPASS_EN
  assign ms_fwd_bus = {ms_valid_q && ms_gr_we, ms_valid_q && ms_mem_re && !ms_ready_go,
                       ms_dest, final_result};
`else
  assign ms_fwd_bus = 39'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/flush/buffer vectors.
module tb_mem_stage;
  localparam int SW  = 150;
  localparam int ESW = 76 + SW;
  localparam int MSW = 71 + SW;

  logic           clk;
  logic           reset;
  logic           es_to_ms_valid;
  logic [ESW-1:0] es_to_ms_bus;
  logic           ms_allowin;
  logic           ws_allowin;
  logic           ms_to_ws_valid;
  logic [MSW-1:0] ms_to_ws_bus;
  logic           data_sram_data_ok;
  logic [31:0]    data_sram_rdata;
  logic           ws_flush_pipe;
  logic           ms_ex;
  logic [38:0]    ms_fwd_bus;

  int tests = 0;
  int fails = 0;
  logic [MSW-1:0] sb[$];

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_flush_pipe(ws_flush_pipe), .ms_ex(ms_ex), .ms_fwd_bus(ms_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ESW-1:0] mk(input logic ex, input logic req, input logic [2:0] mt,
                                        input logic re, input logic we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc,
                                        input logic ertn);
    logic [SW-1:0] s;
    s          = '0;
    s[31:0]    = alu;
    s[32]      = ertn;
    s[149:140] = 10'h2A5;
    return {s, ex, req, mt, re, we, dest, alu, pc};
  endfunction

  function automatic logic [MSW-1:0] expb(input logic [ESW-1:0] b, input logic [31:0] fin);
    return {b[225:76], b[75], b[69], b[68:64], fin, b[31:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && ms_to_ws_valid && ws_allowin) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL ws_unexpected: got %h expected no transfer", ms_to_ws_bus);
      end else begin
        logic [MSW-1:0] e;
        e = sb.pop_front();
        if (ms_to_ws_bus !== e) begin
          fails++;
          $display("FAIL ws_bus: got %h expected %h", ms_to_ws_bus, e);
        end
      end
    end
  end

  task automatic send(input logic [ESW-1:0] b);
    int n;
    n = 0;
    es_to_ms_bus   = b;
    es_to_ms_valid = 1'b1;
    #1;
    while (!ms_allowin && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ms_allowin) begin
      tests++; fails++;
      $display("FAIL send_timeout: got allowin 0 expected 1");
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic load(input logic [ESW-1:0] b, input logic [31:0] rd, input logic [31:0] fin,
                      input int nwait);
    sb.push_back(expb(b, fin));
    send(b);
    for (int i = 0; i < nwait; i++) begin
      #1; check("wait_valid", ms_to_ws_valid, 0);
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1; check("dok_valid", ms_to_ws_valid, 1);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
  endtask

  task automatic ld_vec(input logic [2:0] mt, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] fin, input int nw);
    load(mk(1'b0, 1'b1, mt, 1'b1, 1'b1, 5'd3, alu, 32'h1c00_0000 + alu, 1'b0), rd, fin, nw);
  endtask

  initial begin
    logic [ESW-1:0] b;
    reset = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; ws_flush_pipe = 1'b0;
    #2;
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_allowin", ms_allowin, 1);
    check("rst_ex", ms_ex, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    ld_vec(3'b001, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 2);
    ld_vec(3'b101, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 2);
    ld_vec(3'b010, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001, 1);
    ld_vec(3'b110, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF, 0);
    ld_vec(3'b000, 32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    ld_vec(3'b001, 32'h0000_1000, 32'h80FF_1234, 32'h0000_0034, 0);
    ld_vec(3'b001, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF, 1);
    ld_vec(3'b011, 32'h0000_1001, 32'h80FF_1234, 32'h80FF_1234, 0);
    ld_vec(3'b010, 32'h0000_1000, 32'h0000_8000, 32'hFFFF_8000, 0);

    b = mk(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0000_8004, 32'h1c00_0100, 1'b0);
    load(b, 32'hFFFF_FFFF, 32'h0000_8004, 1);

    b = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h1234_5678, 32'h1c00_0200, 1'b0);
    sb.push_back(expb(b, 32'h1234_5678));
    send(b);
    #1; check("alu_zero_wait", ms_to_ws_valid, 1);
    @(posedge clk); #1;

    // response arrives while WB stalls; the bus value is dropped but the buffer holds it
    ws_allowin = 1'b0;
    b = mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd9, 32'h0000_5000, 32'h1c00_0300, 1'b0);
    sb.push_back(expb(b, 32'hDEAD_BEEF));
    send(b);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1; check("buf_dok_valid", ms_to_ws_valid, 1);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    #1; check("buf_hold_valid", ms_to_ws_valid, 1);
    check("buf_hold_allowin", ms_allowin, 0);
    @(posedge clk); @(posedge clk); #1;
    ws_allowin = 1'b1;
    #1; check("buf_release_allowin", ms_allowin, 1);
    @(posedge clk); #1;
    check("buf_after_valid", ms_to_ws_valid, 0);

    b = mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd5, 32'h0000_9000, 32'h1c00_0400, 1'b0);
    sb.push_back(expb(b, 32'h0BAD_F00D));
    send(b);
    #1;
`ifdef MS_BYPASS_EN
    check("fwd_wait", ms_fwd_bus[38:32], 7'b1100101);
`else
    check("fwd_wait", ms_fwd_bus, 39'd0);
`endif
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;

    // flush a waiting load while EXE also has an issued request: two responses to drop
    send(mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd7, 32'h0000_4000, 32'h1c00_0500, 1'b0));
    es_to_ms_bus   = mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd8, 32'h0000_4004, 32'h1c00_0504, 1'b0);
    es_to_ms_valid = 1'b1;
    ws_flush_pipe  = 1'b1;
    @(posedge clk); #1;
    ws_flush_pipe = 1'b0; es_to_ms_valid = 1'b0;
    #1; check("disc2_allowin", ms_allowin, 0);
    check("disc2_valid", ms_to_ws_valid, 0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    #1; check("disc_dok1_valid", ms_to_ws_valid, 0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    #1; check("disc1_allowin", ms_allowin, 0);
    data_sram_data_ok = 1'b1;
    #1; check("disc_dok2_allowin", ms_allowin, 0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    #1; check("disc0_allowin", ms_allowin, 1);

    // data_ok in the flush cycle belongs to the flushed load, nothing left to discard
    send(mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd6, 32'h0000_4100, 32'h1c00_0600, 1'b0));
    ws_allowin = 1'b0; ws_flush_pipe = 1'b1; data_sram_data_ok = 1'b1;
    @(posedge clk); #1;
    ws_flush_pipe = 1'b0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
    #1; check("flush_dok_allowin", ms_allowin, 1);
    check("flush_dok_valid", ms_to_ws_valid, 0);

    ws_allowin = 1'b0;
    send(mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0000_6000, 32'h1c00_0700, 1'b0));
    #1; check("ex_ms_ex", ms_ex, 1);
    check("ex_valid", ms_to_ws_valid, 1);
    ws_flush_pipe = 1'b1;
    @(posedge clk); #1;
    ws_flush_pipe = 1'b0;
    #1; check("ex_flush_valid", ms_to_ws_valid, 0);
    check("ex_flush_ms_ex", ms_ex, 0);
    ws_allowin = 1'b1;

    b = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0000_7000, 32'h1c00_0800, 1'b1);
    sb.push_back(expb(b, 32'h0000_7000));
    send(b);
    #1; check("ertn_ms_ex", ms_ex, 1);
    @(posedge clk); #1;

    send(mk(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 5'd2, 32'h0000_A000, 32'h1c00_0900, 1'b0));
    reset = 1'b0;
    #1; check("rst_mid_allowin", ms_allowin, 1);
    check("rst_mid_valid", ms_to_ws_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", ms_to_ws_valid, 0);

    repeat (3) @(posedge clk);
    #1; check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
